// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : inst_mem_loader
//  Brief    : Instruction memory with a byte-serial program load engine and a
//             registered fetch port. Bytes are packed big-endian into words,
//             written at auto-incrementing addresses, and the load ends on
//             HALT_WORD or when the memory fills.
//             Optional macro INST_MEM_READBACK_EN adds a registered debug
//             readback port (rb_addr_i / rb_data_o).
//  Revision : 1.0  initial release
// ============================================================================
module inst_mem_loader #(
    parameter int                NB_DATA   = 32,
    parameter int                N_BITS    = 8,
    parameter int                NB_ADDR   = 10,
    parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 load_start_i,
    input  logic [N_BITS-1:0]    byte_i,
    input  logic                 byte_valid_i,
    input  logic                 fetch_en_i,
    input  logic [NB_ADDR-1:0]   pc_i,
    output logic [NB_DATA-1:0]   instruction_o,
    output logic                 load_busy_o,
    output logic                 load_done_o,
    output logic                 overflow_o,
    output logic [NB_ADDR:0]     word_count_o
`ifdef INST_MEM_READBACK_EN
    ,
    input  logic [NB_ADDR-1:0]   rb_addr_i,
    output logic [NB_DATA-1:0]   rb_data_o
`endif
);

    localparam int c_bytes = NB_DATA / N_BITS;
    localparam int c_cnt_w = (c_bytes > 1) ? $clog2(c_bytes) : 1;
    localparam int c_depth = 1 << NB_ADDR;

    localparam logic [c_cnt_w-1:0] c_last_byte = c_cnt_w'(c_bytes - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]          r_state;
    logic [NB_ADDR-1:0]  r_wr_ptr;
    logic [c_cnt_w-1:0]  r_byte_cnt;
    logic [NB_DATA-1:0]  r_asm;
    logic                r_busy;
    logic                r_done;
    logic                r_ovf;
    logic [NB_ADDR:0]    r_word_count;
    logic [NB_DATA-1:0]  r_instr;
    logic [NB_DATA-1:0]  r_mem [0:c_depth-1];

    logic [NB_DATA-1:0]  w_word;
    logic                w_byte_take;
    logic                w_last_byte;
    logic                w_wr_en;
    logic                w_halt;
    logic                w_full;

    // A restart pulse wins over a byte arriving on the same cycle.
    assign w_byte_take = (r_state == c_st_load) && byte_valid_i && !load_start_i;
    assign w_last_byte = (r_byte_cnt == c_last_byte);
    assign w_word      = (r_asm << N_BITS) | NB_DATA'(byte_i);
    assign w_wr_en     = w_byte_take && w_last_byte;
    assign w_halt      = (w_word == HALT_WORD);
    assign w_full      = (r_wr_ptr == {NB_ADDR{1'b1}});

    // Load FSM: byte assembly, write pointer, word count and status flags.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state      <= c_st_idle;
            r_wr_ptr     <= '0;
            r_byte_cnt   <= '0;
            r_asm        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ovf        <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_done <= 1'b0;
            if (load_start_i) begin
                r_state      <= c_st_load;
                r_busy       <= 1'b1;
                r_wr_ptr     <= '0;
                r_byte_cnt   <= '0;
                r_asm        <= '0;
                r_word_count <= '0;
                r_ovf        <= 1'b0;
            end else if (w_byte_take) begin
                if (w_last_byte) begin
                    r_byte_cnt   <= '0;
                    r_asm        <= '0;
                    r_wr_ptr     <= r_wr_ptr + NB_ADDR'(1);
                    r_word_count <= r_word_count + (NB_ADDR + 1)'(1);
                    if (w_halt || w_full) begin
                        r_state <= c_st_done;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_ovf   <= !w_halt;
                    end
                end else begin
                    r_byte_cnt <= r_byte_cnt + c_cnt_w'(1);
                    r_asm      <= w_word;
                end
            end
        end
    end

    // Memory write port; contents survive reset and new loads.
    always_ff @(posedge clock_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // Registered fetch port, held while a load owns the memory.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_instr <= '0;
        end else if (fetch_en_i && (r_state != c_st_load)) begin
            r_instr <= r_mem[pc_i];
        end
    end

`ifdef INST_MEM_READBACK_EN
    logic [NB_DATA-1:0] r_rb_data;

    // Debug readback; a read of the address being written sees old data.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_rb_data <= '0;
        end else begin
            r_rb_data <= r_mem[rb_addr_i];
        end
    end

    assign rb_data_o = r_rb_data;
`endif

    assign instruction_o = r_instr;
    assign load_busy_o   = r_busy;
    assign load_done_o   = r_done;
    assign overflow_o    = r_ovf;
    assign word_count_o  = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_mem_loader
//  Brief    : Self-checking bench for inst_mem_loader (NB_ADDR = 2, depth 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_inst_mem_loader;

    localparam int NB_DATA = 32;
    localparam int N_BITS  = 8;
    localparam int NB_ADDR = 2;

    logic                clk;
    logic                rst;
    logic                load_start;
    logic [N_BITS-1:0]   byte_in;
    logic                byte_valid;
    logic                fetch_en;
    logic [NB_ADDR-1:0]  pc;
    logic [NB_DATA-1:0]  instruction;
    logic                load_busy;
    logic                load_done;
    logic                overflow;
    logic [NB_ADDR:0]    word_count;
`ifdef INST_MEM_READBACK_EN
    logic [NB_ADDR-1:0]  rb_addr;
    logic [NB_DATA-1:0]  rb_data;
`endif

    int n_checks = 0;
    int n_errors = 0;

    inst_mem_loader #(
        .NB_DATA (NB_DATA),
        .N_BITS  (N_BITS),
        .NB_ADDR (NB_ADDR)
    ) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .load_start_i  (load_start),
        .byte_i        (byte_in),
        .byte_valid_i  (byte_valid),
        .fetch_en_i    (fetch_en),
        .pc_i          (pc),
        .instruction_o (instruction),
        .load_busy_o   (load_busy),
        .load_done_o   (load_done),
        .overflow_o    (overflow),
        .word_count_o  (word_count)
`ifdef INST_MEM_READBACK_EN
        ,
        .rb_addr_i     (rb_addr),
        .rb_data_o     (rb_data)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic                start;
        logic                bval;
        logic [N_BITS-1:0]   data;
        logic                fen;
        logic [NB_ADDR-1:0]  pc;
        logic [NB_DATA-1:0]  e_instr;
        logic                e_busy;
        logic                e_done;
        logic                e_ovf;
        logic [NB_ADDR:0]    e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic v, input logic [7:0] d,
                       input logic f, input logic [1:0] p,
                       input logic [31:0] ei, input logic eb, input logic ed,
                       input logic eo, input logic [2:0] ec);
        vec_t t;
        t.start = s; t.bval = v; t.data = d; t.fen = f; t.pc = p;
        t.e_instr = ei; t.e_busy = eb; t.e_done = ed; t.e_ovf = eo; t.e_cnt = ec;
        vecs.push_back(t);
    endtask

    // Apply inputs, clock once, leave time 1 unit after the edge for sampling.
    task automatic drive(input logic r, input logic s, input logic v,
                         input logic [7:0] d, input logic f, input logic [1:0] p);
        rst = r; load_start = s; byte_valid = v; byte_in = d; fetch_en = f; pc = p;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [31:0] ei, input logic eb,
                           input logic ed, input logic eo, input logic [2:0] ec);
        chk({name, ".instr"}, 64'(instruction), 64'(ei));
        chk({name, ".busy"},  64'(load_busy),   64'(eb));
        chk({name, ".done"},  64'(load_done),   64'(ed));
        chk({name, ".ovf"},   64'(overflow),    64'(eo));
        chk({name, ".cnt"},   64'(word_count),  64'(ec));
    endtask

    initial begin
        logic [7:0] bytes12 [12];
        rst = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_in = '0;
        fetch_en = 1'b0; pc = '0;
`ifdef INST_MEM_READBACK_EN
        rb_addr = '0;
`endif

        // ---------------- reset state ----------------
        drive(1, 0, 0, 8'h00, 0, 0);
        drive(1, 0, 0, 8'h00, 1, 0);
        chk_all("reset", 32'h0, 0, 0, 0, 3'd0);

        // ---------------- table: basic load, blocked fetch, restart ----------------
        add(1,0,8'h00,0,0, 32'h0,        1,0,0,3'd0);
        add(0,1,8'h20,0,0, 32'h0,        1,0,0,3'd0);
        add(0,1,8'h01,1,0, 32'h0,        1,0,0,3'd0);
        add(0,1,8'h00,1,0, 32'h0,        1,0,0,3'd0);
        add(0,1,8'h05,1,0, 32'h0,        1,0,0,3'd1);
        add(0,1,8'hFF,1,0, 32'h0,        1,0,0,3'd1);
        add(0,1,8'hFF,1,0, 32'h0,        1,0,0,3'd1);
        add(0,1,8'hFF,1,0, 32'h0,        1,0,0,3'd1);
        add(0,1,8'hFF,1,0, 32'h0,        0,1,0,3'd2);
        add(0,0,8'h00,1,0, 32'h20010005, 0,0,0,3'd2);
        add(0,0,8'h00,1,1, 32'hFFFFFFFF, 0,0,0,3'd2);
        add(0,1,8'h12,1,0, 32'h20010005, 0,0,0,3'd2);
        add(1,0,8'h00,0,0, 32'h20010005, 1,0,0,3'd0);
        add(0,1,8'hAA,0,0, 32'h20010005, 1,0,0,3'd0);
        add(0,1,8'hBB,0,0, 32'h20010005, 1,0,0,3'd0);
        add(1,0,8'h00,0,0, 32'h20010005, 1,0,0,3'd0);
        add(0,1,8'h11,0,0, 32'h20010005, 1,0,0,3'd0);
        add(0,1,8'h22,0,0, 32'h20010005, 1,0,0,3'd0);
        add(0,1,8'h33,0,0, 32'h20010005, 1,0,0,3'd0);
        add(0,1,8'h44,0,0, 32'h20010005, 1,0,0,3'd1);
        add(0,1,8'hFF,0,0, 32'h20010005, 1,0,0,3'd1);
        add(0,1,8'hFF,0,0, 32'h20010005, 1,0,0,3'd1);
        add(0,1,8'hFF,0,0, 32'h20010005, 1,0,0,3'd1);
        add(0,1,8'hFF,0,0, 32'h20010005, 0,1,0,3'd2);
        add(0,0,8'h00,1,0, 32'h11223344, 0,0,0,3'd2);
        add(0,0,8'h00,1,1, 32'hFFFFFFFF, 0,0,0,3'd2);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(0, vecs[i].start, vecs[i].bval, vecs[i].data, vecs[i].fen, vecs[i].pc);
            chk_all($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_busy,
                    vecs[i].e_done, vecs[i].e_ovf, vecs[i].e_cnt);
        end

        // ---------------- back-to-back 12 bytes ----------------
        bytes12 = '{8'hA0,8'hA1,8'hA2,8'hA3, 8'hB0,8'hB1,8'hB2,8'hB3,
                    8'hFF,8'hFF,8'hFF,8'hFF};
        drive(0, 1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 1, bytes12[i], 0, 0);
            if (i == 10) chk("b2b.done_early", 64'(load_done), 64'(0));
        end
        chk("b2b.done",  64'(load_done),  64'(1));
        chk("b2b.busy",  64'(load_busy),  64'(0));
        chk("b2b.cnt",   64'(word_count), 64'(3));
        drive(0, 0, 0, 8'h00, 1, 0);
        chk("b2b.mem0", 64'(instruction), 64'(32'hA0A1A2A3));
        drive(0, 0, 0, 8'h00, 1, 1);
        chk("b2b.mem1", 64'(instruction), 64'(32'hB0B1B2B3));
        drive(0, 0, 0, 8'h00, 1, 2);
        chk("b2b.mem2", 64'(instruction), 64'(32'hFFFFFFFF));

        // ---------------- overflow: 5 non-halt words into depth 4 ----------------
        drive(0, 1, 0, 8'h00, 0, 0);
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 4; b++) begin
                drive(0, 0, 1, 8'((w + 1) * 16 + b), 0, 0);
                if (w == 3 && b == 2) begin
                    chk("ovf.busy_before", 64'(load_busy), 64'(1));
                    chk("ovf.flag_before", 64'(overflow),  64'(0));
                end
            end
        end
        chk_all("ovf.full", 32'hFFFFFFFF, 0, 1, 1, 3'd4);
        for (int b = 0; b < 4; b++) drive(0, 0, 1, 8'h99, 0, 0);
        chk_all("ovf.ignored", 32'hFFFFFFFF, 0, 0, 1, 3'd4);
        drive(0, 0, 0, 8'h00, 1, 0);
        chk("ovf.mem0", 64'(instruction), 64'(32'h10111213));
        drive(0, 0, 0, 8'h00, 1, 3);
        chk("ovf.mem3", 64'(instruction), 64'(32'h40414243));

        // ---------------- reset mid-load ----------------
        drive(0, 1, 0, 8'h00, 0, 0);
        chk("rst.ovf_cleared", 64'(overflow), 64'(0));
        drive(0, 0, 1, 8'hCA, 0, 0);
        drive(0, 0, 1, 8'hFE, 0, 0);
        drive(0, 0, 1, 8'hBA, 0, 0);
        drive(0, 0, 1, 8'hBE, 0, 0);
        drive(0, 0, 1, 8'h12, 0, 0);
        drive(0, 0, 1, 8'h34, 0, 0);
        chk("rst.cnt_before", 64'(word_count), 64'(1));
        drive(1, 0, 1, 8'h56, 1, 1);
        chk_all("rst.values", 32'h0, 0, 0, 0, 3'd0);
        drive(0, 0, 0, 8'h00, 1, 0);
        chk_all("rst.mem0", 32'hCAFEBABE, 0, 0, 0, 3'd0);
        drive(0, 0, 0, 8'h00, 1, 1);
        chk("rst.mem1_kept", 64'(instruction), 64'(32'h20212223));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_mem_loader.md
# inst_mem_loader

Parametrised instruction memory with a byte-serial load engine, successor to the word-wide load path. The debug unit streams program bytes (from the UART) into this block. The block assembles them into `NB_DATA`-bit instructions, writes them at auto-incrementing addresses and detects end-of-program. The processor fetch stage reads instructions through a registered fetch port.

## Interface
- `NB_DATA`, 32, instruction width; must be a multiple of `N_BITS`.
- `N_BITS`, 8, width of one load byte.
- `NB_ADDR`, 10, address width; memory depth is 2^`NB_ADDR` words.
- `HALT_WORD`, 32'hFFFF_FFFF, instruction value that terminates a load.

Ports:
- `clock_i`  in  1  single clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `load_start_i`  in  1  pulse; starts a new program load.
- `byte_i`  in  `N_BITS`  load byte.
- `byte_valid_i`  in  1  `byte_i` is valid this cycle.
- `fetch_en_i`  in  1  fetch request.
- `pc_i`  in  `NB_ADDR`  fetch word address.
- `instruction_o`  out  `NB_DATA`  fetched instruction, registered.
- `load_busy_o`  out  1  high in state LOAD.
- `load_done_o`  out  1  one-cycle pulse when a load finishes.
- `overflow_o`  out  1  sticky; the memory filled before `HALT_WORD` arrived.
- `word_count_o`  out  `NB_ADDR`+1  number of words written by the current or last load.

## Operation
- The FSM has three states: IDLE, LOAD and DONE. Reset forces IDLE.
- **IDLE / DONE + `load_start_i`**
  - Next state is LOAD.
  - Write pointer, byte counter and `word_count_o` clear to 0.
  - `overflow_o` clears.
  - Memory contents are not cleared.
- **LOAD + `byte_valid_i`**
  - The byte shifts into the assembly register, big-endian: the first byte becomes bits [`NB_DATA`-1 -: `N_BITS`].
  - The byte counter increments.
- **Word completion.** The byte that completes a word (byte counter = `NB_DATA`/`N_BITS` - 1) triggers these actions on the same edge:
  - The assembled word is written to `mem[wr_ptr]`.
  - `wr_ptr` and `word_count_o` increment.
  - The byte counter returns to 0.
- **End of program.** If the completed word equals `HALT_WORD`:
  - The word is still written.
  - The FSM goes to DONE and `load_done_o` pulses.
- **Memory full.** If `wr_ptr` = 2^`NB_ADDR`-1 and a non-halt word completes:
  - The word is written.
  - The FSM goes to DONE, `load_done_o` pulses and `overflow_o` sets.
- **Ignored inputs.**
  - `byte_valid_i` in IDLE or DONE is ignored.
  - `load_start_i` during LOAD restarts the load: counters clear and any partial word is discarded.
- **Fetch outside LOAD.** When `fetch_en_i` is high, `instruction_o` is loaded with `mem[pc_i]`.
- **Fetch during LOAD.**
  - Fetch is ignored and `instruction_o` holds its value.
  - The block never performs a simultaneous read and write.
- **Fetch disabled.** When `fetch_en_i` is low, `instruction_o` holds its value.

## Timing
- **Reset values:** `instruction_o`=0, `load_busy_o`=0, `load_done_o`=0, `overflow_o`=0, `word_count_o`=0, state IDLE.
- **Fetch latency:** 1 cycle. `pc_i` sampled at edge N appears on `instruction_o` after edge N.
- **Write latency:**
  - Memory is updated on the edge that samples the completing byte.
  - A fetch of that address issued one cycle after DONE is entered returns the new word.
- **Load state signals:**
  - `load_busy_o` rises the cycle after `load_start_i` is sampled.
  - `load_busy_o` falls in the same cycle that `load_done_o` is high.
- **Accepted byte rate:** one byte per cycle, back-to-back.
- **Reset mid-load:**
  - The FSM returns to IDLE and the partial word is lost.
  - Words already written remain in memory.

## Configuration
- **`INST_MEM_READBACK_EN` defined:**
  - Adds port `rb_addr_i` (in, `NB_ADDR`) and port `rb_data_o` (out, `NB_DATA`, reset 0).
  - `rb_data_o` is registered with 1-cycle latency and is readable in any state.
  - The debug unit uses it to verify a load.
  - If `rb_addr_i` equals `wr_ptr` on a write edge, `rb_data_o` returns the old contents (read-before-write).
- **`INST_MEM_READBACK_EN` undefined:**
  - The readback ports are absent.
  - The memory has a single read port.

## Test plan
- **Basic load and fetch.** `load_start_i`, then bytes 8'h20,8'h01,8'h00,8'h05 and 8'hFF×4. Required response: `word_count_o`=2, `load_done_o` pulses once, `overflow_o`=0. Fetch `pc_i`=0 gives 32'h2001_0005; fetch `pc_i`=1 gives 32'hFFFF_FFFF.
- **Back-to-back bytes.** 12 bytes on consecutive cycles, ending in the halt word. Required response: 3 words written, no byte dropped, `load_done_o` on the cycle after the 12th byte is sampled.
- **Overflow.** With `NB_ADDR`=2, load 5 non-halt words. Required response: DONE after word 4, `overflow_o`=1, `word_count_o`=4, the 5th word's bytes ignored.
- **Restart mid-word.** `load_start_i`, 2 bytes, `load_start_i`, then a full word plus the halt word. Required response: `mem[0]` holds the new word and `word_count_o`=2.
- **Fetch blocked during load.** Assert `fetch_en_i` with `pc_i`=0 during LOAD. Required response: `instruction_o` unchanged; after DONE it updates with 1-cycle latency.
- **Reset mid-load.** Assert `reset_i` after 1.5 words. Required response: all outputs at their reset values, `mem[0]` retained, and a fetch of `pc_i`=0 after reset returns it.
